// File: rtl/conv_layer_engine_if.sv
// Handshake/data bundle between a conv_layer_engine and its feeder/consumer.
// master = feeder side (drives pixels, weights, bias, ack); slave = engine side.
interface conv_layer_engine_if #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 112,
  parameter int AW     = 12
);
  logic                                layer_en;
  logic [WIDTH-1:0]                    ifm;
  logic [DSP_NO-1:0][WIDTH-1:0]        ker;
  logic [DSP_NO-1:0][2*WIDTH-1:0]      bias;
  logic                                ram_feedback;
  logic [AW-1:0]                       weight_addr;
  logic [DSP_NO-1:0][WIDTH-1:0]        ofm;
  logic                                sample;
  logic                                finish;

  modport master (
    output layer_en, ifm, ker, bias, ram_feedback,
    input  weight_addr, ofm, sample, finish
  );

  modport slave (
    input  layer_en, ifm, ker, bias, ram_feedback,
    output weight_addr, ofm, sample, finish
  );
endinterface

// File: rtl/conv_layer_engine.sv
// Multi-lane MAC engine: one output pixel per DEPTH accepted steps, WOUT**2 pixels per layer.
// Optional macro CONV_RELU_EN clamps negative outputs to zero.
module conv_layer_engine #(
  parameter int WIDTH      = 16,
  parameter int DSP_NO     = 112,
  parameter int CHIN       = 384,
  parameter int KERNEL_DIM = 3,
  parameter int WOUT       = 8,
  parameter int FRAC       = 14
) (
  input  logic clk,
  input  logic rst,
  conv_layer_engine_if.slave bus
);
  localparam int DEPTH = KERNEL_DIM * KERNEL_DIM * CHIN;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ACCW  = 2 * WIDTH + AW;
  localparam int SW    = ACCW + 1;
  localparam int NPIX  = WOUT * WOUT;
  localparam int PW    = $clog2(NPIX + 1);

  localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                        state_q;
  logic [AW-1:0]                 addr_q;
  logic [PW-1:0]                 pix_q;
  logic                          emit_q;
  logic                          ack_q;
  logic                          sample_q;
  logic                          finish_q;
  logic [DSP_NO-1:0][WIDTH-1:0]  ofm_q;
  logic signed [ACCW-1:0]        acc_q [DSP_NO];

  logic                          last_pix;
  logic                          accept;
  logic                          wrap;
  logic                          ack_d;
  logic                          done_d;
  logic signed [2*WIDTH-1:0]     prod     [DSP_NO];
  logic signed [ACCW-1:0]        prod_ext [DSP_NO];
  logic [WIDTH-1:0]              res      [DSP_NO];

  // Bias add, arithmetic shift (floor), saturate, optional ReLU.
  function automatic logic [WIDTH-1:0] post(input logic signed [ACCW-1:0] acc,
                                            input logic [2*WIDTH-1:0] b);
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sh;
    logic signed [SW-1:0] clp;
    sum = {acc[ACCW-1], acc} + {{(SW-2*WIDTH){b[2*WIDTH-1]}}, b};
    sh  = sum >>> FRAC;
    if (sh > MAXV)      clp = MAXV;
    else if (sh < MINV) clp = MINV;
    else                clp = sh;
`ifdef CONV_RELU_EN
    if (clp[SW-1]) clp = '0;
`endif
    return clp[WIDTH-1:0];
  endfunction

  always_comb begin
    last_pix = emit_q && (pix_q == PW'(NPIX - 1));
    // The final pixel's emit cycle already belongs to DONE, so no new step may start in it.
    accept   = bus.layer_en && (state_q != DONE) && !last_pix;
    wrap     = (addr_q == AW'(DEPTH - 1));
    ack_d    = ack_q | bus.ram_feedback;
    done_d   = (state_q == DONE) || last_pix;
    for (int i = 0; i < DSP_NO; i++) begin
      prod[i]     = $signed(bus.ifm) * $signed(bus.ker[i]);
      prod_ext[i] = {{AW{prod[i][2*WIDTH-1]}}, prod[i]};
      res[i]      = post(acc_q[i], bus.bias[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      pix_q    <= '0;
      emit_q   <= 1'b0;
      ack_q    <= 1'b0;
      sample_q <= 1'b0;
      finish_q <= 1'b0;
      ofm_q    <= '0;
      for (int i = 0; i < DSP_NO; i++) acc_q[i] <= '0;
    end else begin
      sample_q <= emit_q;
      ack_q    <= ack_d;
      finish_q <= done_d && !ack_d;
      emit_q   <= accept && wrap;
      if (accept) addr_q <= wrap ? '0 : addr_q + AW'(1);

      case (state_q)
        IDLE:    if (accept) state_q <= ACCUM;
        ACCUM:   if (last_pix) state_q <= DONE;
        default: state_q <= DONE;
      endcase

      if (emit_q) begin
        pix_q <= pix_q + PW'(1);
        for (int i = 0; i < DSP_NO; i++) ofm_q[i] <= res[i];
      end

      for (int i = 0; i < DSP_NO; i++) begin
        if (emit_q)      acc_q[i] <= accept ? prod_ext[i] : '0;
        else if (accept) acc_q[i] <= acc_q[i] + prod_ext[i];
      end
    end
  end

  assign bus.weight_addr = addr_q;
  assign bus.ofm         = ofm_q;
  assign bus.sample      = sample_q;
  assign bus.finish      = finish_q;
endmodule

// File: tb/tb_conv_layer_engine.sv
// Scoreboard bench: two engines (FRAC=0 and FRAC=4) share stimulus; expected ofm words are
// queued at issue time and popped by per-engine monitors on each sample strobe.
module tb_conv_layer_engine;
`ifdef CONV_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic layer_en = 1'b0;
  logic [15:0] ifm = '0;
  logic [1:0][15:0] ker = '0;
  logic [1:0][31:0] bias = '0;
  logic ram_feedback = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] q0 [$];
  logic [31:0] q4 [$];

  always #5 clk = ~clk;

  conv_layer_engine_if #(.WIDTH(16), .DSP_NO(2), .AW(1)) b0 ();
  conv_layer_engine_if #(.WIDTH(16), .DSP_NO(2), .AW(1)) b4 ();

  assign b0.layer_en = layer_en;     assign b4.layer_en = layer_en;
  assign b0.ifm = ifm;               assign b4.ifm = ifm;
  assign b0.ker = ker;               assign b4.ker = ker;
  assign b0.bias = bias;             assign b4.bias = bias;
  assign b0.ram_feedback = ram_feedback;
  assign b4.ram_feedback = ram_feedback;

  conv_layer_engine #(.WIDTH(16), .DSP_NO(2), .CHIN(2), .KERNEL_DIM(1), .WOUT(2), .FRAC(0))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  conv_layer_engine #(.WIDTH(16), .DSP_NO(2), .CHIN(2), .KERNEL_DIM(1), .WOUT(2), .FRAC(4))
    dut4 (.clk(clk), .rst(rst), .bus(b4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] r(input int v);
    return (RELU && v < 0) ? 16'd0 : 16'(v);
  endfunction

  // Expected lane0/lane1 for FRAC=0 engine, then FRAC=4 engine (pre-ReLU hand values).
  task automatic push(input int a0, input int a1, input int c0, input int c1);
    q0.push_back({r(a1), r(a0)});
    q4.push_back({r(c1), r(c0)});
  endtask

  always @(negedge clk) begin
    if (!rst && b0.sample) begin
      if (q0.size() == 0) chk("ofm0_unexpected_sample", 32'd1, 32'd0);
      else chk("ofm0", b0.ofm, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && b4.sample) begin
      if (q4.size() == 0) chk("ofm4_unexpected_sample", 32'd1, 32'd0);
      else chk("ofm4", b4.ofm, q4.pop_front());
    end
  end

  task automatic step(input logic [15:0] x, input logic [15:0] k0, input logic [15:0] k1);
    layer_en = 1'b1;
    ifm = x;
    ker[0] = k0;
    ker[1] = k1;
    @(posedge clk);
    #1 layer_en = 1'b0;
  endtask

  // Two steps, then sample must be low one half-cycle later and high after the next edge.
  task automatic finish_pixel(input string tag);
    @(negedge clk);
    chk({tag, "_sample_early"}, {31'd0, b0.sample}, 32'd0);
    @(negedge clk);
    chk({tag, "_sample_pulse"}, {31'd0, b0.sample}, 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_addr0"}, {31'd0, b0.weight_addr}, 32'd0);
    chk({tag, "_ofm0"}, b0.ofm, 32'd0);
    chk({tag, "_ofm4"}, b4.ofm, 32'd0);
    chk({tag, "_sample"}, {31'd0, b0.sample | b4.sample}, 32'd0);
    chk({tag, "_finish"}, {31'd0, b0.finish | b4.finish}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Pixel 1: 3*2*2=12, 3*-1*2=-6; FRAC=4 gives 0 and -1 (floor).
    push(12, -6, 0, -1);
    step(16'd3, 16'd2, 16'hFFFF);
    @(negedge clk);
    chk("addr_after_step1", {31'd0, b0.weight_addr}, 32'd1);
    step(16'd3, 16'd2, 16'hFFFF);
    finish_pixel("pix1");
    chk("finish_low_pix1", {31'd0, b0.finish}, 32'd0);

    // Pixel 2: same data, 5-cycle stall between the steps.
    push(12, -6, 0, -1);
    step(16'd3, 16'd2, 16'hFFFF);
    repeat (5) @(negedge clk);
    chk("stall_addr_hold", {31'd0, b0.weight_addr}, 32'd1);
    chk("stall_ofm_hold", b0.ofm, {r(-6), r(12)});
    step(16'd3, 16'd2, 16'hFFFF);
    finish_pixel("pix2");

    // Pixel 3: saturation both ways.
    push(32767, -32768, 32767, -32768);
    step(16'h7FFF, 16'h7FFF, 16'h8001);
    step(16'h7FFF, 16'h7FFF, 16'h8001);
    finish_pixel("pix3");
    chk("finish_low_pix3", {31'd0, b0.finish}, 32'd0);

    // Pixel 4: zero products, bias +/-256 -> FRAC=4 gives 16 / -16.
    bias[0] = 32'd256;
    bias[1] = -32'sd256;
    push(256, -256, 16, -16);
    step(16'd0, 16'd5, 16'd5);
    step(16'd0, 16'd5, 16'd5);
    finish_pixel("pix4");
    chk("finish_high0", {31'd0, b0.finish}, 32'd1);
    chk("finish_high4", {31'd0, b4.finish}, 32'd1);

    // Layer done: further steps are ignored.
    step(16'd7, 16'd1, 16'd1);
    step(16'd7, 16'd1, 16'd1);
    step(16'd7, 16'd1, 16'd1);
    repeat (3) @(negedge clk);
    chk("done_addr_hold", {31'd0, b0.weight_addr}, 32'd0);
    chk("done_ofm_hold", b4.ofm, {r(-16), 16'd16});
    chk("done_finish_hold", {31'd0, b0.finish}, 32'd1);

    ram_feedback = 1'b1;
    @(posedge clk);
    #1 ram_feedback = 1'b0;
    @(negedge clk);
    chk("ack_finish_drop", {31'd0, b0.finish}, 32'd0);
    repeat (4) @(negedge clk);
    chk("ack_finish_stays", {31'd0, b0.finish | b4.finish}, 32'd0);

    // New layer after reset; one full pixel, then a partial one aborted by reset.
    bias = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(8, 8, 0, 0);
    step(16'd1, 16'd4, 16'd4);
    step(16'd1, 16'd4, 16'd4);
    finish_pixel("pixB0");
    step(16'd5, 16'd1, 16'd1);
    #3 rst = 1'b1;
    #1 chk_reset_state("midreset");
    @(negedge clk);
    rst = 1'b0;

    // Early ack: finish must stay suppressed when the layer completes.
    ram_feedback = 1'b1;
    @(posedge clk);
    #1 ram_feedback = 1'b0;

    // Back-to-back pixels: the next pixel's first step lands in the emit cycle.
    push(12, -12, 0, -1);
    push(10, -10, 0, -1);
    push(0, 0, 0, 0);
    push(0, 0, 0, 0);
    step(16'd2, 16'd3, 16'hFFFD);
    step(16'd2, 16'd3, 16'hFFFD);
    step(16'd1, 16'd5, 16'hFFFB);
    step(16'd1, 16'd5, 16'hFFFB);
    step(16'd0, 16'd9, 16'd9);
    step(16'd0, 16'd9, 16'd9);
    step(16'd0, 16'd9, 16'd9);
    step(16'd0, 16'd9, 16'd9);
    repeat (4) @(negedge clk);
    chk("early_ack_no_finish", {31'd0, b0.finish | b4.finish}, 32'd0);
    chk("queue0_drained", q0.size(), 32'd0);
    chk("queue4_drained", q4.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
